// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings and helpers for the load/store unit
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    // Reserved size maps to 4 so the bounds check stays well defined; it is rejected anyway
    function automatic logic [2:0] byte_count(input logic [1:0] size);
        return size == SZ_BYTE ? 3'd1 : size == SZ_HALF ? 3'd2 : 3'd4;
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// lsu_extend: sign/zero extension of the low 8n bits of an accumulator to 32 bits
module lsu_extend (
    input  logic [31:0] acc,
    input  logic [2:0]  n,
    input  logic        sgn,
    output logic [31:0] result
);

    assign result = n == 3'd1 ? {{24{sgn & acc[7]}}, acc[7:0]} :
                    n == 3'd2 ? {{16{sgn & acc[15]}}, acc[15:0]} : acc;

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: sized load/store sequencer driving a byte-wide memory, big-endian
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 401
) (
    input  logic        CLK,
    input  logic        Reset_n,
    input  logic        Req,
    input  logic        RW,
    input  logic [1:0]  Size,
    input  logic        Signed,
    input  logic [31:0] DAddr,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        Ack,
    output logic        Err,
    output logic        Busy,
    output logic [31:0] MemAddr,
    output logic [7:0]  MemWData,
    output logic        MemWE,
    input  logic [7:0]  MemRData
);

    state_t      state;
    logic        rw, sgn, err_f, bad, last;
    logic [2:0]  n, req_n;
    logic [1:0]  k, sh;
    logic [23:0] acc;
    logic [31:0] addr, wdata, acc_next, ext;
    logic [32:0] last_addr;

    assign req_n     = byte_count(Size);
    // 33-bit sum so an address that wraps past 0xFFFFFFFF is seen as out of range
    assign last_addr = {1'b0, DAddr} + 33'(req_n) - 33'd1;
    assign bad       = Size == 2'b11 ||
                       (Size == SZ_HALF && DAddr[0]) ||
                       (Size == SZ_WORD && DAddr[1:0] != 2'b00) ||
                       last_addr > 33'(MEM_BYTES - 1);
    assign last      = {1'b0, k} == n - 3'd1;
    assign acc_next  = {acc, MemRData};
    // First byte on the bus is the most significant one of the sized data
    assign sh        = 2'(n - 3'd1 - {1'b0, k});

    assign Busy     = state != IDLE;
    assign Ack      = state == DONE;
    assign Err      = state == DONE && err_f;
    assign MemWE    = state == ACCESS && rw;
    assign MemAddr  = state == ACCESS ? addr + {30'd0, k} : 32'd0;
    assign MemWData = MemWE ? wdata[{sh, 3'b000} +: 8] : 8'd0;

    lsu_extend u_extend (
        .acc    (acc_next),
        .n      (n),
        .sgn    (sgn),
        .result (ext)
    );

    // Request capture, byte sequencing and load result registration
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= IDLE;
            rw      <= 1'b0;
            sgn     <= 1'b0;
            err_f   <= 1'b0;
            n       <= 3'd1;
            k       <= 2'd0;
            addr    <= 32'd0;
            wdata   <= 32'd0;
            acc     <= 24'd0;
            DataOut <= 32'd0;
        end else begin
            case (state)
                IDLE: if (Req) begin
                    rw    <= RW;
                    sgn   <= Signed;
                    addr  <= DAddr;
                    wdata <= DataIn;
                    n     <= req_n;
                    k     <= 2'd0;
                    acc   <= 24'd0;
                    err_f <= bad;
                    state <= bad ? DONE : ACCESS;
                end
                ACCESS: begin
                    acc <= acc_next[23:0];
                    k   <= k + 2'd1;
                    if (last) begin
                        state <= DONE;
                        if (!rw) DataOut <= ext;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vector bench for load_store_unit with a byte memory model
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int MB = 401;

    logic        CLK = 1'b0, Reset_n = 1'b0, Req = 1'b0, RW = 1'b0, Signed = 1'b0;
    logic [1:0]  Size = 2'b00;
    logic [31:0] DAddr = 32'd0, DataIn = 32'd0;
    logic [31:0] DataOut, MemAddr;
    logic        Ack, Err, Busy, MemWE;
    logic [7:0]  MemWData, MemRData;
    logic [7:0]  mem [MB];
    int          n_checks = 0, n_fail = 0, we_count = 0, ack_count = 0;

    typedef struct {
        logic        rw;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] a;
        logic [31:0] d;
        int          cyc;
        logic        err;
        logic [31:0] dout;
        int          we;
    } vec_t;

    vec_t v [19];

    always #5 CLK = ~CLK;

    load_store_unit #(.MEM_BYTES(MB)) dut (
        .CLK      (CLK),
        .Reset_n  (Reset_n),
        .Req      (Req),
        .RW       (RW),
        .Size     (Size),
        .Signed   (Signed),
        .DAddr    (DAddr),
        .DataIn   (DataIn),
        .DataOut  (DataOut),
        .Ack      (Ack),
        .Err      (Err),
        .Busy     (Busy),
        .MemAddr  (MemAddr),
        .MemWData (MemWData),
        .MemWE    (MemWE),
        .MemRData (MemRData)
    );

    assign MemRData = MemAddr < 32'(MB) ? mem[MemAddr[8:0]] : 8'h00;

    always @(posedge CLK) begin
        if (MemWE && MemAddr < 32'(MB)) mem[MemAddr[8:0]] <= MemWData;
        we_count  <= we_count + int'(MemWE);
        ack_count <= ack_count + int'(Ack);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run(input logic rw, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] d,
                       output int cyc, output logic e, output int we);
        int we0;
        @(negedge CLK);
        we0 = we_count;
        RW = rw; Size = sz; Signed = sg; DAddr = a; DataIn = d; Req = 1'b1;
        @(posedge CLK);
        #1 Req = 1'b0;
        cyc = 0;
        e = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge CLK);
            if (Ack) begin
                cyc = c;
                e = Err;
                break;
            end
        end
        we = we_count - we0;
    endtask

    initial begin
        int cyc, we, a0;
        logic e;
        logic [7:0] m21;

        v[0]  = '{1'b1, 2'b10, 1'b0, 32'd8,   32'h12345678, 5, 1'b0, 32'h00000000, 4};
        v[1]  = '{1'b0, 2'b10, 1'b0, 32'd8,   32'h0,        5, 1'b0, 32'h12345678, 0};
        v[2]  = '{1'b1, 2'b00, 1'b0, 32'd20,  32'hAAAAAAF0, 2, 1'b0, 32'h12345678, 1};
        v[3]  = '{1'b0, 2'b00, 1'b1, 32'd20,  32'h0,        2, 1'b0, 32'hFFFFFFF0, 0};
        v[4]  = '{1'b0, 2'b00, 1'b0, 32'd20,  32'h0,        2, 1'b0, 32'h000000F0, 0};
        v[5]  = '{1'b0, 2'b01, 1'b0, 32'd10,  32'h0,        3, 1'b0, 32'h00005678, 0};
        v[6]  = '{1'b1, 2'b01, 1'b0, 32'd30,  32'hFFFF9ABC, 3, 1'b0, 32'h00005678, 2};
        v[7]  = '{1'b0, 2'b01, 1'b1, 32'd30,  32'h0,        3, 1'b0, 32'hFFFF9ABC, 0};
        v[8]  = '{1'b0, 2'b01, 1'b0, 32'd9,   32'h0,        1, 1'b1, 32'hFFFF9ABC, 0};
        v[9]  = '{1'b0, 2'b11, 1'b0, 32'd0,   32'h0,        1, 1'b1, 32'hFFFF9ABC, 0};
        v[10] = '{1'b1, 2'b10, 1'b0, 32'd396, 32'hCAFEF00D, 5, 1'b0, 32'hFFFF9ABC, 4};
        v[11] = '{1'b0, 2'b10, 1'b0, 32'd396, 32'h0,        5, 1'b0, 32'hCAFEF00D, 0};
        v[12] = '{1'b0, 2'b10, 1'b0, 32'd400, 32'h0,        1, 1'b1, 32'hCAFEF00D, 0};
        v[13] = '{1'b0, 2'b01, 1'b0, 32'd400, 32'h0,        1, 1'b1, 32'hCAFEF00D, 0};
        v[14] = '{1'b1, 2'b00, 1'b0, 32'd400, 32'h0000005A, 2, 1'b0, 32'hCAFEF00D, 1};
        v[15] = '{1'b0, 2'b00, 1'b1, 32'd400, 32'h0,        2, 1'b0, 32'h0000005A, 0};
        v[16] = '{1'b1, 2'b10, 1'b0, 32'hFFFFFFFC, 32'h55667788, 1, 1'b1, 32'h0000005A, 0};
        v[17] = '{1'b1, 2'b10, 1'b0, 32'd1,   32'h55667788, 1, 1'b1, 32'h0000005A, 0};
        v[18] = '{1'b0, 2'b01, 1'b0, 32'd30,  32'h0,        3, 1'b0, 32'h00009ABC, 0};

        #2;
        check("rst DataOut", DataOut, 32'd0);
        check("rst Ack/Err/Busy", {29'd0, Ack, Err, Busy}, 32'd0);
        check("rst MemWE", {31'd0, MemWE}, 32'd0);
        check("rst MemAddr", MemAddr, 32'd0);
        check("rst MemWData", {24'd0, MemWData}, 32'd0);
        repeat (2) @(negedge CLK);
        Reset_n = 1'b1;
        m21 = mem[21];

        for (int i = 0; i < 19; i++) begin
            run(v[i].rw, v[i].sz, v[i].sg, v[i].a, v[i].d, cyc, e, we);
            check($sformatf("v%0d ack cycle", i), 32'(cyc), 32'(v[i].cyc));
            check($sformatf("v%0d err", i), {31'd0, e}, {31'd0, v[i].err});
            check($sformatf("v%0d DataOut", i), DataOut, v[i].dout);
            check($sformatf("v%0d write count", i), 32'(we), 32'(v[i].we));
        end

        check("mem8..11", {mem[8], mem[9], mem[10], mem[11]}, 32'h12345678);
        check("mem20", {24'd0, mem[20]}, 32'h000000F0);
        check("mem21 untouched", {24'd0, mem[21]}, {24'd0, m21});
        check("mem30..31", {16'd0, mem[30], mem[31]}, 32'h00009ABC);
        check("mem396..399", {mem[396], mem[397], mem[398], mem[399]}, 32'hCAFEF00D);
        check("mem400", {24'd0, mem[400]}, 32'h0000005A);

        // Req while busy is dropped: only one Ack
        @(negedge CLK);
        a0 = ack_count;
        RW = 1'b0; Size = 2'b10; Signed = 1'b0; DAddr = 32'd8; Req = 1'b1;
        @(posedge CLK);
        #1 Req = 1'b0;
        @(negedge CLK);
        check("busy cycle1", {31'd0, Busy}, 32'd1);
        @(negedge CLK);
        Size = 2'b00; DAddr = 32'd20; Req = 1'b1;
        @(posedge CLK);
        #1 Req = 1'b0;
        repeat (8) @(negedge CLK);
        check("busy req ack count", 32'(ack_count - a0), 32'd1);
        check("busy req DataOut", DataOut, 32'h12345678);

        // Reset in the middle of a word store
        run(1'b1, 2'b10, 1'b0, 32'd0, 32'h11223344, cyc, e, we);
        check("pre-reset store ack", 32'(cyc), 32'd5);
        @(negedge CLK);
        RW = 1'b1; Size = 2'b10; DAddr = 32'd0; DataIn = 32'hA0B0C0D0; Req = 1'b1;
        @(posedge CLK);
        #1 Req = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        Reset_n = 1'b0;
        #1;
        a0 = ack_count;
        check("midrst MemWE", {31'd0, MemWE}, 32'd0);
        check("midrst Busy/Ack/Err", {29'd0, Busy, Ack, Err}, 32'd0);
        check("midrst MemAddr", MemAddr, 32'd0);
        check("midrst MemWData", {24'd0, MemWData}, 32'd0);
        check("midrst DataOut", DataOut, 32'd0);
        @(negedge CLK);
        Reset_n = 1'b1;
        repeat (6) @(negedge CLK);
        check("midrst no ack", 32'(ack_count - a0), 32'd0);
        check("midrst mem1..3", {8'd0, mem[1], mem[2], mem[3]}, 32'h00223344);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
